// File: rtl/matrixmult_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrixmult_mac_pkg
// Description : Shared constants and saturation-limit helpers for the
//               dot-product multiply-accumulate block.
// Revision    : 1.0 - initial release
// ============================================================================
package matrixmult_mac_pkg;

    localparam int c_DIN0_WIDTH_DEF = 16;
    localparam int c_DIN1_WIDTH_DEF = 16;
    localparam int c_NUM_STAGE_DEF  = 2;
    localparam int c_ACC_WIDTH_DEF  = 40;
    localparam int c_NUM_STAGE_MIN  = 1;
    localparam int c_NUM_STAGE_MAX  = 4;

    // Limits are built wide and sliced down to ACC_WIDTH by the user.
    localparam int c_SAT_W = 128;
    typedef logic [c_SAT_W-1:0] sat_const_t;

    function automatic sat_const_t sat_max(input int acc_w, input bit is_signed);
        sat_const_t v;
        if (is_signed) v = (sat_const_t'(1) << (acc_w - 1)) - sat_const_t'(1);
        else           v = (sat_const_t'(1) << acc_w) - sat_const_t'(1);
        return v;
    endfunction

    function automatic sat_const_t sat_min(input int acc_w, input bit is_signed);
        sat_const_t v;
        if (is_signed) v = sat_const_t'(1) << (acc_w - 1);
        else           v = '0;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrixmult_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : matrixmult_mul_pipe
// Description : Full-width multiplier followed by NUM_STAGE registers with a
//               valid/last sideband travelling alongside the product.
// Revision    : 1.0 - initial release
// ============================================================================
module matrixmult_mul_pipe
    import matrixmult_mac_pkg::*;
#(
    parameter int DIN0_WIDTH  = c_DIN0_WIDTH_DEF,
    parameter int DIN1_WIDTH  = c_DIN1_WIDTH_DEF,
    parameter int NUM_STAGE   = c_NUM_STAGE_DEF,
    parameter int SIGNED_MODE = 1
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_ce,
    input  logic                             i_valid,
    input  logic                             i_last,
    input  logic [DIN0_WIDTH-1:0]            i_din0,
    input  logic [DIN1_WIDTH-1:0]            i_din1,
    output logic                             o_valid,
    output logic                             o_last,
    output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] o_prod
);

    localparam int c_PROD_W = DIN0_WIDTH + DIN1_WIDTH;

    logic                w_a_sign;
    logic                w_b_sign;
    logic [c_PROD_W-1:0] w_a_ext;
    logic [c_PROD_W-1:0] w_b_ext;
    logic [c_PROD_W-1:0] w_prod;

    // Extending both operands to the product width makes a plain modular
    // multiply yield the exact signed or unsigned product.
    assign w_a_sign = (SIGNED_MODE != 0) && i_din0[DIN0_WIDTH-1];
    assign w_b_sign = (SIGNED_MODE != 0) && i_din1[DIN1_WIDTH-1];
    assign w_a_ext  = {{DIN1_WIDTH{w_a_sign}}, i_din0};
    assign w_b_ext  = {{DIN0_WIDTH{w_b_sign}}, i_din1};
    assign w_prod   = w_a_ext * w_b_ext;

    logic [c_PROD_W-1:0]  r_prod [NUM_STAGE];
    logic [NUM_STAGE-1:0] r_valid;
    logic [NUM_STAGE-1:0] r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_last  <= '0;
            for (int i = 0; i < NUM_STAGE; i++) r_prod[i] <= '0;
        end else if (i_ce) begin
            r_prod[0]  <= w_prod;
            r_valid[0] <= i_valid;
            r_last[0]  <= i_valid && i_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_prod[i]  <= r_prod[i-1];
                r_valid[i] <= r_valid[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    assign o_prod  = r_prod[NUM_STAGE-1];
    assign o_valid = r_valid[NUM_STAGE-1];
    assign o_last  = r_last[NUM_STAGE-1];

endmodule
`default_nettype wire

// File: rtl/matrixmult_dot_mac.sv
`default_nettype none
// ============================================================================
// Module      : matrixmult_dot_mac
// Description : Streaming dot-product MAC: pipelined multiply, one-register
//               accumulate with overflow detect/saturate, registered result.
// Revision    : 1.0 - initial release
// ============================================================================
module matrixmult_dot_mac
    import matrixmult_mac_pkg::*;
#(
    parameter int DIN0_WIDTH  = c_DIN0_WIDTH_DEF,
    parameter int DIN1_WIDTH  = c_DIN1_WIDTH_DEF,
    parameter int NUM_STAGE   = c_NUM_STAGE_DEF,
    parameter int ACC_WIDTH   = c_ACC_WIDTH_DEF,
    parameter int SIGNED_MODE = 1,
    parameter int SATURATE    = 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  out_ovf
);

    localparam int         c_PROD_W   = DIN0_WIDTH + DIN1_WIDTH;
    localparam sat_const_t c_MAX_FULL = sat_max(ACC_WIDTH, SIGNED_MODE != 0);
    localparam sat_const_t c_MIN_FULL = sat_min(ACC_WIDTH, SIGNED_MODE != 0);
    localparam logic [ACC_WIDTH-1:0] c_MAX = c_MAX_FULL[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] c_MIN = c_MIN_FULL[ACC_WIDTH-1:0];

    logic                 w_pv;
    logic                 w_pl;
    logic [c_PROD_W-1:0]  w_prod;
    logic                 w_prod_sign;
    logic [ACC_WIDTH-1:0] w_prod_ext;

    matrixmult_mul_pipe #(
        .DIN0_WIDTH  (DIN0_WIDTH),
        .DIN1_WIDTH  (DIN1_WIDTH),
        .NUM_STAGE   (NUM_STAGE),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_mul_pipe (
        .clk     (clk),
        .rst     (reset),
        .i_ce    (ce),
        .i_valid (in_valid),
        .i_last  (in_last),
        .i_din0  (din0),
        .i_din1  (din1),
        .o_valid (w_pv),
        .o_last  (w_pl),
        .o_prod  (w_prod)
    );

    assign w_prod_sign = (SIGNED_MODE != 0) && w_prod[c_PROD_W-1];

    generate
        if (ACC_WIDTH > c_PROD_W) begin : g_ext
            assign w_prod_ext = {{(ACC_WIDTH-c_PROD_W){w_prod_sign}}, w_prod};
        end else begin : g_noext
            assign w_prod_ext = w_prod[ACC_WIDTH-1:0];
        end
    endgenerate

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_acc_ovf;
    logic                 r_first;
    logic                 r_fin;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_dout;
    logic                 r_out_ovf;

    logic                 w_acc_top;
    logic                 w_prod_top;
    logic [ACC_WIDTH:0]   w_sum_x;
    logic                 w_ovf;
    logic [ACC_WIDTH-1:0] w_sum;

    // One guard bit: its disagreement with the MSB (signed) or its value
    // alone (unsigned carry) flags an overflow of ACC_WIDTH.
    assign w_acc_top  = (SIGNED_MODE != 0) && r_acc[ACC_WIDTH-1];
    assign w_prod_top = (SIGNED_MODE != 0) && w_prod_ext[ACC_WIDTH-1];
    assign w_sum_x    = {w_acc_top, r_acc} + {w_prod_top, w_prod_ext};
    assign w_ovf      = (SIGNED_MODE != 0) ? (w_sum_x[ACC_WIDTH] ^ w_sum_x[ACC_WIDTH-1])
                                           : w_sum_x[ACC_WIDTH];

    always_comb begin
        w_sum = w_sum_x[ACC_WIDTH-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            if ((SIGNED_MODE != 0) && w_sum_x[ACC_WIDTH]) w_sum = c_MIN;
            else                                          w_sum = c_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
            r_first     <= 1'b1;
            r_fin       <= 1'b0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_out_ovf   <= 1'b0;
        end else if (ce) begin
            r_fin <= w_pv && w_pl;
            if (w_pv) begin
                r_first <= w_pl;
                if (r_first) begin
                    r_acc     <= w_prod_ext;
                    r_acc_ovf <= 1'b0;
                end else begin
                    r_acc     <= w_sum;
                    r_acc_ovf <= r_acc_ovf | w_ovf;
                end
            end
            r_out_valid <= r_fin;
            if (r_fin) begin
                r_dout    <= r_acc;
                r_out_ovf <= r_acc_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_matrixmult_dot_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrixmult_dot_mac
// Description : Directed self-checking bench; three instances share stimulus
//               (defaults, 32-bit saturating, 32-bit wrapping).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrixmult_dot_mac;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] din0 = '0;
    logic [15:0] din1 = '0;

    logic        dv, sv, wv;
    logic [39:0] dd;
    logic [31:0] sd, wd;
    logic        dof, sof, wof;

    int checks = 0;
    int errors = 0;
    int dpulses = 0;

    always #5 clk = ~clk;

    matrixmult_dot_mac u_def (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(dv), .dout(dd), .out_ovf(dof)
    );

    matrixmult_dot_mac #(.ACC_WIDTH(32), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(sv), .dout(sd), .out_ovf(sof)
    );

    matrixmult_dot_mac #(.ACC_WIDTH(32), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(wv), .dout(wd), .out_ovf(wof)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (dv) dpulses++;
    endtask

    task automatic step(input logic c, input logic v, input logic l, input int a, input int b);
        ce       = c;
        in_valid = v;
        in_last  = l;
        din0     = 16'(a);
        din1     = 16'(b);
        tick();
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        check("rst_valid", dv, 0);
        check("rst_dout", $signed(dd), 0);
        check("rst_ovf", dof, 0);
        reset = 1'b0;

        // Basic 4-beat vector: 1*5+2*6+3*7+4*8 = 70, latency 3
        step(1, 1, 0, 1, 5);
        step(1, 1, 0, 2, 6);
        step(1, 1, 0, 3, 7);
        step(1, 1, 1, 4, 8);
        idle(); check("basic_lat1", dv, 0);
        idle(); check("basic_lat2", dv, 0);
        idle(); check("basic_valid", dv, 1);
        check("basic_dout", $signed(dd), 70);
        check("basic_ovf", dof, 0);
        idle(); check("basic_pulse", dv, 0);
        check("basic_hold", $signed(dd), 70);

        // Back-to-back single-beat vectors
        step(1, 1, 1, -3, 7);
        step(1, 1, 1, 32767, -32768);
        idle();
        idle(); check("b2b_v1", dv, 1);
        check("b2b_d1", $signed(dd), -21);
        idle(); check("b2b_v2", dv, 1);
        check("b2b_d2", $signed(dd), -1073709056);
        check("b2b_ovf", dof, 0);
        idle(); check("b2b_end", dv, 0);

        // Positive overflow, then a fresh 1*1 vector right behind it
        step(1, 1, 0, 32767, 32767);
        step(1, 1, 0, 32767, 32767);
        step(1, 1, 1, 32767, 32767);
        step(1, 1, 1, 1, 1);
        idle();
        idle();
        check("sat_valid", sv, 1);
        check("sat_dout", $signed(sd), 2147483647);
        check("sat_ovf", sof, 1);
        check("wrap_dout", $signed(wd), -1073938429);
        check("wrap_ovf", wof, 1);
        check("wide_dout", $signed(dd), 64'sd3221028867);
        check("wide_ovf", dof, 0);
        idle();
        check("sat_next_dout", $signed(sd), 1);
        check("sat_next_ovf", sof, 0);
        check("wrap_next_dout", $signed(wd), 1);
        check("wrap_next_ovf", wof, 0);

        // Negative overflow; the final +1 continues from the clamped minimum
        step(1, 1, 0, -32768, 32767);
        step(1, 1, 0, -32768, 32767);
        step(1, 1, 0, -32768, 32767);
        step(1, 1, 1, 1, 1);
        idle();
        idle();
        idle();
        check("neg_sat_valid", sv, 1);
        check("neg_sat_dout", $signed(sd), -2147483647);
        check("neg_sat_ovf", sof, 1);
        check("neg_wrap_dout", $signed(wd), 1073840129);
        check("neg_wrap_ovf", wof, 1);
        check("neg_wide_dout", $signed(dd), -64'sd3221127167);
        idle();

        // Gaps plus ce low mid-pipeline: 30-80-150+240 = 40
        step(1, 1, 0, 10, 3);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, -20, 4);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 30, -5);
        step(1, 1, 1, 40, 6);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 99, 99);
            check("ce_gate_quiet", dv, 0);
        end
        idle(); check("ce_lat1", dv, 0);
        idle(); check("ce_lat2", dv, 0);
        idle(); check("ce_valid", dv, 1);
        check("ce_dout", $signed(dd), 40);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            check("ce_hold_valid", dv, 1);
        end
        idle(); check("ce_pulse_end", dv, 0);
        check("ce_hold_dout", $signed(dd), 40);

        // Reset mid-vector: aborted data must not appear; 2*3+4*5 = 26
        step(1, 1, 0, 100, 100);
        step(1, 1, 0, 50, 50);
        reset = 1'b1;
        step(1, 1, 1, 7, 7);
        reset = 1'b0;
        check("rst2_dout", $signed(dd), 0);
        check("rst2_valid", dv, 0);
        dpulses = 0;
        step(1, 1, 0, 2, 3);
        step(1, 1, 1, 4, 5);
        idle();
        idle();
        check("abort_quiet", dpulses, 0);
        idle();
        check("abort_valid", dv, 1);
        check("abort_dout", $signed(dd), 26);
        for (int i = 0; i < 4; i++) idle();
        check("abort_pulses", dpulses, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrixmult_dot_mac.md
MATRIXMULT_DOT_MAC -- requirements
Module: matrixmult_dot_mac

Interface
REQ-001 The block SHALL have parameter DIN0_WIDTH, default 16, width of operand din0.
REQ-002 The block SHALL have parameter DIN1_WIDTH, default 16, width of operand din1.
REQ-003 The block SHALL have parameter NUM_STAGE, default 2, multiplier pipeline depth, legal range 1..4.
REQ-004 The block SHALL have parameter ACC_WIDTH, default 40, accumulator and result width, which SHALL be at least DIN0_WIDTH+DIN1_WIDTH.
REQ-005 The block SHALL have parameter SIGNED_MODE, default 1: 1 treats operands as two's complement, 0 treats them as unsigned.
REQ-006 The block SHALL have parameter SATURATE, default 1: 1 clamps on overflow, 0 wraps.
REQ-007 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
  clk  in  1  clock; all state updates on the rising edge
  reset  in  1  synchronous active-high reset
  ce  in  1  clock enable; when low, all state holds
  in_valid  in  1  din0/din1/in_last carry a beat
  in_last  in  1  beat is the final element of the current dot product
  din0  in  DIN0_WIDTH  operand A element
  din1  in  DIN1_WIDTH  operand B element
  out_valid  out  1  dout/out_ovf carry a completed dot product
  dout  out  ACC_WIDTH  dot-product result
  out_ovf  out  1  the completed result overflowed ACC_WIDTH

Function
REQ-008 A beat SHALL be accepted on a rising edge where ce=1, in_valid=1 and reset=0; there SHALL be no backpressure.
REQ-009 The product SHALL be full width (DIN0_WIDTH+DIN1_WIDTH), signed or unsigned per SIGNED_MODE, and extended to ACC_WIDTH by sign- or zero-extension to match.
REQ-010 The product SHALL traverse NUM_STAGE registers, with valid and last carried alongside, all advancing only when ce=1.
REQ-011 The accumulate stage SHALL be one register: if the incoming beat is the first of a vector, acc = product; otherwise acc = acc + product.
REQ-012 The first beat of a vector SHALL be the first valid beat after reset or after a beat with in_last=1.
REQ-013 When a beat with last=1 reaches the accumulate stage, the block SHALL load dout with the final sum and assert out_valid for exactly one ce-qualified cycle.
REQ-014 Latency SHALL be NUM_STAGE+1 ce=1 cycles from acceptance of the last beat to out_valid=1.
REQ-015 Back-to-back vectors SHALL need no bubble: the first beat of vector N+1 SHALL enter the accumulate stage the cycle after vector N's last beat, with a fresh sum.
REQ-016 A single-beat vector (in_valid=1, in_last=1) SHALL produce dout equal to that single product.
REQ-017 Bubbles (in_valid=0) SHALL leave acc unchanged and SHALL NOT end a vector.
REQ-018 Overflow SHALL be detected per addition by comparing the signed result (or the unsigned carry) against ACC_WIDTH.
REQ-019 With SATURATE=1, an overflowing sum SHALL clamp to the ACC_WIDTH max/min, and further additions SHALL continue from the clamped value.
REQ-020 With SATURATE=0, an overflowing sum SHALL wrap modulo 2^ACC_WIDTH.
REQ-021 The overflow flag SHALL be sticky within a vector, presented on out_ovf with the result, and cleared at the next first beat.
REQ-022 dout and out_ovf SHALL hold their values until the next result; out_valid SHALL fall after one ce=1 cycle.
REQ-023 With ce=0, all registers, including out_valid, SHALL hold; consumers SHALL qualify out_valid with ce.

Reset
REQ-024 On reset=1 at a rising edge: out_valid=0, dout=0, out_ovf=0, acc=0, all pipeline valid/last bits=0, first-beat flag=1.
REQ-025 Reset SHALL override ce and in_valid.
REQ-026 A vector in progress at reset SHALL be discarded and SHALL produce no output.

Structure
REQ-027 Package matrixmult_mac_pkg SHALL hold the default width constants, the NUM_STAGE legal bounds, and the saturation max/min constant functions of ACC_WIDTH.
REQ-028 Sub-module matrixmult_mul_pipe SHALL implement the NUM_STAGE-deep multiplier with the valid/last sideband.
REQ-029 The accumulator, overflow detection and output registers SHALL reside in matrixmult_dot_mac.

Verification
REQ-030 Defaults; vector din0={1,2,3,4}, din1={5,6,7,8}, last on beat 4 -> out_valid exactly 3 cycles after beat 4, dout=70, out_ovf=0.
REQ-031 Back-to-back single-beat vectors (-3×7) then (32767×-32768) -> consecutive out_valid pulses, dout=-21 then -1073709056.
REQ-032 ACC_WIDTH=32, SATURATE=1, three beats of 32767×32767 -> dout=2147483647, out_ovf=1; the next vector 1×1 gives dout=1, out_ovf=0.
REQ-033 Same as REQ-032 with SATURATE=0 -> dout equals the wrapped sum (-1073938429), out_ovf=1.
REQ-034 Vector of 4 beats with in_valid gaps and ce held low for 5 cycles mid-pipeline -> dout matches the ungated sum, latency counts only ce=1 cycles, and out_valid is held while ce=0.
REQ-035 Reset asserted after beat 2 of 4, then a new 2-beat vector 2×3, 4×5 -> no output for the aborted vector, dout=26.
